// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the core (M0)
// and the loader/debug port (M1), with bounded bursts and tagged read return.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   mX_req/addr/wr_*    requester X transaction request (held until mX_gnt)
//   mX_gnt              combinational accept for this cycle
//   mX_rd_data/rd_valid read return, one cycle after a granted read
//   mem_*               single-port memory interface (1-cycle read latency)
module mem_port_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int FIRST_PRI = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wr_data,
    input  logic        m0_wr_ena,
    output logic        m0_gnt,
    output logic [31:0] m0_rd_data,
    output logic        m0_rd_valid,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wr_data,
    input  logic        m1_wr_ena,
    output logic        m1_gnt,
    output logic [31:0] m1_rd_data,
    output logic        m1_rd_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr_ena,
    input  logic [31:0] mem_rd_data
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);
    // Seeding last_owner with the other side makes the first tie go to FIRST_PRI.
    localparam logic LAST_RST = (FIRST_PRI == 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          pend_q, pend_d;
    logic          tag_q, tag_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            tag_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            tag_q   <= tag_d;
        end
    end

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        m0_gnt      = 1'b0;
        m1_gnt      = 1'b0;
        state_d     = IDLE;
        last_d      = last_q;
        cnt_d       = '0;
        pend_d      = 1'b0;
        tag_d       = tag_q;
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_wr_ena  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (m0_req && m1_req) begin
                    m0_gnt = last_q;
                    m1_gnt = ~last_q;
                end else begin
                    m0_gnt = m0_req;
                    m1_gnt = m1_req;
                end
            end
            OWN0: begin
                // Owner keeps the port until its burst is used up,
                // unless nobody else wants it.
                if (m0_req && (cnt_q < CNT_MAX || !m1_req))
                    m0_gnt = 1'b1;
                else
                    m1_gnt = m1_req;
            end
            OWN1: begin
                if (m1_req && (cnt_q < CNT_MAX || !m0_req))
                    m1_gnt = 1'b1;
                else
                    m0_gnt = m0_req;
            end
            default: ;
        endcase

        // No grant may be issued while reset is held.
        if (!rst) begin
            m0_gnt = 1'b0;
            m1_gnt = 1'b0;
        end

        if (m0_gnt) begin
            state_d     = OWN0;
            last_d      = 1'b0;
            cnt_d       = (state_q == OWN0) ? cnt_inc : '0;
            pend_d      = ~m0_wr_ena;
            tag_d       = 1'b0;
            mem_addr    = m0_addr;
            mem_wr_data = m0_wr_data;
            mem_wr_ena  = m0_wr_ena;
        end else if (m1_gnt) begin
            state_d     = OWN1;
            last_d      = 1'b1;
            cnt_d       = (state_q == OWN1) ? cnt_inc : '0;
            pend_d      = ~m1_wr_ena;
            tag_d       = 1'b1;
            mem_addr    = m1_addr;
            mem_wr_data = m1_wr_data;
            mem_wr_ena  = m1_wr_ena;
        end
    end

    assign m0_rd_valid = pend_q && !tag_q;
    assign m1_rd_valid = pend_q && tag_q;
    assign m0_rd_data  = mem_rd_data;
    assign m1_rd_data  = mem_rd_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic
// checked against a run-length round-robin reference model.
module tb_mem_port_arbiter;

    localparam int MAX_BURST = 4;
    localparam int FIRST_PRI = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_wr_ena, m0_gnt, m0_rd_valid;
    logic [31:0] m0_addr, m0_wr_data, m0_rd_data;
    logic        m1_req, m1_wr_ena, m1_gnt, m1_rd_valid;
    logic [31:0] m1_addr, m1_wr_data, m1_rd_data;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
    logic        mem_wr_ena;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_BURST(MAX_BURST), .FIRST_PRI(FIRST_PRI)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
        .m0_wr_ena(m0_wr_ena), .m0_gnt(m0_gnt), .m0_rd_data(m0_rd_data),
        .m0_rd_valid(m0_rd_valid),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
        .m1_wr_ena(m1_wr_ena), .m1_gnt(m1_gnt), .m1_rd_data(m1_rd_data),
        .m1_rd_valid(m1_rd_valid),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_ena(mem_wr_ena), .mem_rd_data(mem_rd_data)
    );

    function automatic bit [31:0] init_val(input int i);
        if (i == 4) return 32'hDEADBEEF;
        return 32'(i) * 32'h9E3779B1;
    endfunction

    // Memory device: 256 words, 1-cycle read latency.
    bit [31:0]  mem [256];
    bit [255:0] written;
    always @(posedge clk) begin
        if (mem_wr_ena) begin
            mem[mem_addr[9:2]]     <= mem_wr_data;
            written[mem_addr[9:2]] <= 1'b1;
        end
        mem_rd_data <= written[mem_addr[9:2]] ? mem[mem_addr[9:2]]
                                              : init_val(int'(mem_addr[9:2]));
    end

    // Reference state
    bit [31:0]  ref_mem [256];
    bit [255:0] ref_wr;
    int         mdl_prev, mdl_run, mdl_last, mdl_tag, wait0, wait1;
    bit         mdl_pend;
    bit [31:0]  mdl_rdata;
    int         n_chk = 0;
    int         n_fail = 0;
    logic       ob_v0, ob_v1;
    logic [31:0] ob_rd;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [31:0] ref_rd(input logic [31:0] a);
        int i = int'(a[9:2]);
        return ref_wr[i] ? ref_mem[i] : init_val(i);
    endfunction

    task automatic mdl_reset();
        mdl_prev = -1;
        mdl_run  = 0;
        mdl_last = (FIRST_PRI == 0) ? 1 : 0;
        mdl_pend = 1'b0;
        mdl_tag  = 0;
        wait0    = 0;
        wait1    = 0;
    endtask

    // One cycle: drive, check against the model, advance the model.
    task automatic step(input logic r0, input logic [31:0] a0,
                        input logic [31:0] d0, input logic w0,
                        input logic r1, input logic [31:0] a1,
                        input logic [31:0] d1, input logic w1,
                        output int g);
        int eg, o;
        bit ro, rx, wr;
        logic [31:0] ea, ed;
        m0_req = r0; m0_addr = a0; m0_wr_data = d0; m0_wr_ena = w0;
        m1_req = r1; m1_addr = a1; m1_wr_data = d1; m1_wr_ena = w1;
        #1;
        chk("rdv0", 32'(m0_rd_valid), 32'(mdl_pend && mdl_tag == 0));
        chk("rdv1", 32'(m1_rd_valid), 32'(mdl_pend && mdl_tag == 1));
        if (mdl_pend)
            chk("rdata", (mdl_tag == 0) ? m0_rd_data : m1_rd_data, mdl_rdata);
        ob_v0 = m0_rd_valid;
        ob_v1 = m1_rd_valid;
        ob_rd = ob_v1 ? m1_rd_data : m0_rd_data;

        eg = -1;
        if (mdl_prev < 0) begin
            if (r0 && r1) eg = (mdl_last == 0) ? 1 : 0;
            else if (r0)  eg = 0;
            else if (r1)  eg = 1;
        end else begin
            o  = mdl_prev;
            ro = (o == 0) ? r0 : r1;
            rx = (o == 0) ? r1 : r0;
            if (ro && (mdl_run < MAX_BURST || !rx)) eg = o;
            else if (rx) eg = 1 - o;
        end
        chk("gnt0", 32'(m0_gnt), 32'(eg == 0));
        chk("gnt1", 32'(m1_gnt), 32'(eg == 1));

        ea = (eg == 0) ? a0 : (eg == 1) ? a1 : 32'h0;
        ed = (eg == 0) ? d0 : (eg == 1) ? d1 : 32'h0;
        wr = (eg == 0) ? w0 : (eg == 1) ? w1 : 1'b0;
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wr_data, ed);
        chk("mem_wena", 32'(mem_wr_ena), 32'(wr));

        if (eg >= 0) begin
            mdl_run  = (eg == mdl_prev) ? mdl_run + 1 : 1;
            mdl_last = eg;
            if (wr) begin
                ref_mem[ea[9:2]] = ed;
                ref_wr[ea[9:2]]  = 1'b1;
            end
            mdl_pend  = !wr;
            mdl_tag   = eg;
            mdl_rdata = ref_rd(ea);
        end else begin
            mdl_run  = 0;
            mdl_pend = 1'b0;
        end
        mdl_prev = eg;

        if (r0 && eg != 0) begin
            if (eg == 1) wait0++;
        end else wait0 = 0;
        if (r1 && eg != 1) begin
            if (eg == 0) wait1++;
        end else wait1 = 0;
        chk("starve0", 32'(wait0 <= MAX_BURST), 32'd1);
        chk("starve1", 32'(wait1 <= MAX_BURST), 32'd1);

        g = m0_gnt ? 0 : (m1_gnt ? 1 : -1);
        @(negedge clk);
    endtask

    task automatic idle(output int g);
        step(0, 0, 0, 0, 0, 0, 0, 0, g);
    endtask

    initial begin
        int g;
        int exp_seq[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        int exp_t4[4]   = '{1, 1, 1, 0};
        bit p0, p1, r0, r1, w0, w1;
        logic [31:0] a0, a1, d0, d1;

        rst = 1'b0;
        m0_req = 0; m0_addr = 0; m0_wr_data = 0; m0_wr_ena = 0;
        m1_req = 0; m1_addr = 0; m1_wr_data = 0; m1_wr_ena = 0;
        repeat (2) @(negedge clk);
        m0_req = 1; m1_req = 1;
        #1;
        chk("rst_gnt0", 32'(m0_gnt), 0);
        chk("rst_gnt1", 32'(m1_gnt), 0);
        chk("rst_rdv", 32'({m0_rd_valid, m1_rd_valid}), 0);
        chk("rst_wena", 32'(mem_wr_ena), 0);
        chk("rst_addr", mem_addr, 0);
        @(negedge clk);
        rst = 1'b1;
        mdl_reset();

        // Continuous contention after reset: bursts of four, no gaps.
        for (int i = 0; i < 10; i++) begin
            step(1, 32'h100, 0, 0, 1, 32'h200, 0, 0, g);
            chk($sformatf("burst%0d", i), 32'(g), 32'(exp_seq[i]));
        end
        idle(g);
        idle(g);

        // M0 lone read of preloaded word.
        step(1, 32'h10, 0, 0, 0, 0, 0, 0, g);
        chk("t1_gnt", 32'(g), 0);
        idle(g);
        chk("t1_v0", 32'(ob_v0), 1);
        chk("t1_v1", 32'(ob_v1), 0);
        chk("t1_data", ob_rd, 32'hDEADBEEF);

        // M1 write then readback.
        step(0, 0, 0, 0, 1, 32'h40, 32'h12345678, 1, g);
        chk("t3_gnt", 32'(g), 1);
        idle(g);
        chk("t3_nov", 32'({ob_v0, ob_v1}), 0);
        step(0, 0, 0, 0, 1, 32'h40, 0, 0, g);
        idle(g);
        chk("t3_v1", 32'(ob_v1), 1);
        chk("t3_data", ob_rd, 32'h12345678);

        // M0 owns with one repeat, drops req: M1 takes over at once, fresh burst.
        step(1, 32'h20, 0, 0, 0, 0, 0, 0, g);
        step(1, 32'h24, 0, 0, 0, 0, 0, 0, g);
        step(0, 0, 0, 0, 1, 32'h30, 0, 0, g);
        chk("t4_switch", 32'(g), 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 32'h20, 0, 0, 1, 32'h30, 0, 0, g);
            chk($sformatf("t4_seq%0d", i), 32'(g), 32'(exp_t4[i]));
        end
        idle(g);

        // Reset lands while a read is in flight.
        step(1, 32'h10, 0, 0, 0, 0, 0, 0, g);
        #1;
        chk("t5_pre_v0", 32'(m0_rd_valid), 1);
        rst = 1'b0;
        #1;
        chk("t5_v0", 32'(m0_rd_valid), 0);
        chk("t5_v1", 32'(m1_rd_valid), 0);
        chk("t5_gnt", 32'({m0_gnt, m1_gnt}), 0);
        m1_req = 1;
        @(negedge clk);
        #1;
        chk("t5_held", 32'({m0_gnt, m1_gnt}), 0);
        chk("t5_hv", 32'({m0_rd_valid, m1_rd_valid}), 0);
        @(negedge clk);
        rst = 1'b1;
        mdl_reset();
        step(1, 32'h50, 0, 0, 1, 32'h54, 0, 0, g);
        chk("t5_first", 32'(g), FIRST_PRI);

        // Random traffic; requesters hold their request until granted.
        p0 = 0; p1 = 0;
        r0 = 0; r1 = 0; w0 = 0; w1 = 0;
        a0 = 0; a1 = 0; d0 = 0; d1 = 0;
        for (int c = 0; c < 10000; c++) begin
            if (!p0) begin
                r0 = ($urandom_range(0, 9) < 7);
                w0 = ($urandom_range(0, 9) < 3);
                a0 = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                d0 = $urandom;
            end
            if (!p1) begin
                r1 = ($urandom_range(0, 9) < 6);
                w1 = ($urandom_range(0, 9) < 3);
                a1 = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                d1 = $urandom;
            end
            step(r0, a0, d0, w0, r1, a1, d1, w1, g);
            p0 = r0 && (g != 0);
            p1 = r1 && (g != 1);
        end
        idle(g);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
